// File: rtl/iqdemap_ctrl.sv
// iqdemap_ctrl: per-symbol carrier reader for the QPSK demapper.
// Reads one symbol from RAM, strips pilot/TMCC carriers, streams data through a 1-entry skid.
module iqdemap_ctrl #(
  parameter int unsigned W    = 11,
  parameter int unsigned NCAR = 432,
  parameter int unsigned AW   = 9
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                sym_start,
  output logic                rd_en,
  output logic [AW-1:0]       rd_addr,
  input  logic [2*W:0]        rd_data,
  input  logic                stall_i,
  output logic                valid_o,
  output logic signed [W-1:0] ar_o,
  output logic signed [W-1:0] ai_o,
  output logic                sym_done,
  output logic [AW:0]         data_cnt,
  output logic                overrun
);

  localparam int unsigned   DW        = 2 * W;
  localparam int unsigned   CW        = AW + 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(NCAR - 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          rvalid_q, rvalid_d;
  logic          out_v_q, out_v_d;
  logic [DW-1:0] out_q, out_d;
  logic          skid_v_q, skid_v_d;
  logic [DW-1:0] skid_q, skid_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] dcnt_q, dcnt_d;
  logic          done_q, done_d;
  logic          ovr_q, ovr_d;
  logic          xfer, out_free, rin, rd_issue;

  // Next-state, output register and skid steering
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    out_v_d  = out_v_q;
    out_d    = out_q;
    skid_v_d = skid_v_q;
    skid_d   = skid_q;
    cnt_d    = cnt_q;
    dcnt_d   = dcnt_q;
    done_d   = 1'b0;
    ovr_d    = ovr_q;
    rd_issue = 1'b0;

    xfer     = out_v_q & ~stall_i;
    out_free = ~out_v_q | xfer;
    rin      = rvalid_q & ~rd_data[DW];

    if (xfer) begin
      out_v_d = 1'b0;
      cnt_d   = cnt_q + CW'(1);
    end
    if (skid_v_q && out_free) begin
      out_d    = skid_q;
      out_v_d  = 1'b1;
      skid_v_d = 1'b0;
    end
    if (rin) begin
      if (!skid_v_q && out_free) begin
        out_d   = rd_data[DW-1:0];
        out_v_d = 1'b1;
      end else begin
        skid_d   = rd_data[DW-1:0];
        skid_v_d = 1'b1;
      end
    end

    if (sym_start && state_q != IDLE) ovr_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (sym_start) begin
          state_d = READ;
          addr_d  = '0;
          cnt_d   = '0;
        end
      end
      READ: begin
        // Read strobe is combinational: a read goes out only when the skid will be
        // empty after this edge, so its data always has a slot one cycle later.
        rd_issue = ~skid_v_d;
        if (rd_issue) begin
          if (addr_q == LAST_ADDR) state_d = DRAIN;
          else                     addr_d  = addr_q + AW'(1);
        end
      end
      DRAIN: begin
        if (!rvalid_q && !skid_v_q && !out_v_q) begin
          state_d = DONE;
          done_d  = 1'b1;
          dcnt_d  = cnt_q;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    rvalid_d = rd_issue;
  end

  // State and datapath registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      rvalid_q <= 1'b0;
      out_v_q  <= 1'b0;
      out_q    <= '0;
      skid_v_q <= 1'b0;
      skid_q   <= '0;
      cnt_q    <= '0;
      dcnt_q   <= '0;
      done_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      rvalid_q <= rvalid_d;
      out_v_q  <= out_v_d;
      out_q    <= out_d;
      skid_v_q <= skid_v_d;
      skid_q   <= skid_d;
      cnt_q    <= cnt_d;
      dcnt_q   <= dcnt_d;
      done_q   <= done_d;
      ovr_q    <= ovr_d;
    end
  end

  assign rd_en    = rd_issue;
  assign rd_addr  = addr_q;
  assign valid_o  = out_v_q;
  assign ar_o     = out_q[DW-1:W];
  assign ai_o     = out_q[W-1:0];
  assign sym_done = done_q;
  assign data_cnt = dcnt_q;
  assign overrun  = ovr_q;

endmodule
